i2c_master_interface: RTL and testbench

Single-master I2C bus engine, clocked at 200 MHz. It executes complete write or read transactions on request from a device controller (e.g. the MAX1238 ADC controller): START, 7-bit address, data bytes, STOP. Read data is returned as right-justified words, one per channel group. It drives open-drain SCL/SDA through external tri-state buffers and sits between the device controller and the board pins.

---
 rtl/i2c_master_interface.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_master_interface.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_interface.sv
// Single-master I2C engine: START, 7-bit address, write or grouped read bytes, STOP.
// SCL/SDA are registered open-drain drive enables; every bit is four QUARTER-cycle phases.
module i2c_master_interface #(
  parameter int QUARTER = 500
) (
  input  logic        CLK_200M,
  input  logic        reset,
  input  logic        wr_flg,
  input  logic        rd_flg,
  input  logic [6:0]  adr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  wr_bytes,
  input  logic [2:0]  rd_bytes,
  input  logic [3:0]  rd_channels,
  output logic [31:0] rd_data,
  output logic        rd_data_en,
  output logic        scl_o,
  output logic        sda_o,
  input  logic        sda_i,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, WDATA, ACK_W, RDATA, MACK, STOP, FREE
  } state_t;

  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);

  function automatic logic [2:0] clamp_wr(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

  function automatic logic [2:0] clamp_rd(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

  state_t      state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic        rw_q, rw_d;
  logic [2:0]  wrem_q, wrem_d;
  logic [2:0]  rdb_q, rdb_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic        nack_q, nack_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_en_q, rd_en_d;
  logic [6:0]  adr_q, adr_d;
  logic [7:0]  tx_q, tx_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rx_q, rx_d;

  logic       qend, bend, sample, last_byte;
  logic [2:0] wr_n, rd_n;
  logic [3:0] ch_n;

  assign qend      = (qcnt_q == QLAST);
  assign bend      = qend && (qtr_q == 2'd3);
  assign sample    = qend && (qtr_q == 2'd2);
  assign last_byte = (bcnt_q == 3'd1) && (gcnt_q == 4'd1);
  assign wr_n      = clamp_wr(wr_bytes);
  assign rd_n      = clamp_rd(rd_bytes);
  assign ch_n      = (rd_channels == 4'd0) ? 4'd1 : rd_channels;

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    wrem_d    = wrem_q;
    rdb_d     = rdb_q;
    bcnt_d    = bcnt_q;
    gcnt_d    = gcnt_q;
    nack_d    = nack_q;
    rd_data_d = rd_data_q;
    rd_en_d   = 1'b0;
    adr_d     = adr_q;
    tx_d      = tx_q;
    wbuf_d    = wbuf_q;
    rx_d      = rx_q;

    // Quarter/phase timebase runs whenever a transaction is active; qtr wraps 3->0 at each bit end.
    if (state_q != IDLE) begin
      qcnt_d = qend ? '0 : qcnt_q + QW'(1);
      if (qend) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (wr_flg || rd_flg) begin
          state_d = START;
          qcnt_d  = '0;
          qtr_d   = 2'd0;
          rw_d    = !wr_flg;
          adr_d   = adr;
          wbuf_d  = wr_data << {3'd4 - wr_n, 3'b000};
          wrem_d  = wr_n;
          rdb_d   = rd_n;
          bcnt_d  = rd_n;
          gcnt_d  = ch_n;
          rx_d    = '0;
        end
      end
      START: begin
        if (qend && qtr_q == 2'd1) begin
          state_d = ADDR;
          qtr_d   = 2'd0;
          bit_d   = 3'd7;
          tx_d    = {adr_q, rw_q};
        end
      end
      ADDR, WDATA: begin
        if (bend) begin
          if (bit_q == 3'd0) begin
            state_d = (state_q == ADDR) ? ACK_A : ACK_W;
          end else begin
            bit_d = bit_q - 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
      end
      ACK_A, ACK_W: begin
        if (sample) nack_d = sda_i;
        if (bend) begin
          if (nack_q) begin
            state_d = STOP;
          end else if (rw_q) begin
            state_d = RDATA;
            bit_d   = 3'd7;
          end else if (wrem_q == 3'd0) begin
            state_d = STOP;
          end else begin
            state_d = WDATA;
            bit_d   = 3'd7;
            tx_d    = wbuf_q[31:24];
            wbuf_d  = {wbuf_q[23:0], 8'h00};
            wrem_d  = wrem_q - 3'd1;
          end
        end
      end
      RDATA: begin
        if (sample) rx_d = {rx_q[30:0], sda_i};
        if (bend) begin
          if (bit_q == 3'd0) state_d = MACK;
          else bit_d = bit_q - 3'd1;
        end
      end
      MACK: begin
        if (bend) begin
          bit_d = 3'd7;
          if (bcnt_q == 3'd1) begin
            rd_data_d = rx_q;
            rd_en_d   = 1'b1;
            rx_d      = '0;
            if (gcnt_q == 4'd1) begin
              state_d = STOP;
            end else begin
              state_d = RDATA;
              gcnt_d  = gcnt_q - 4'd1;
              bcnt_d  = rdb_q;
            end
          end else begin
            state_d = RDATA;
            bcnt_d  = bcnt_q - 3'd1;
          end
        end
      end
      STOP: begin
        if (qend && qtr_q == 2'd1) begin
          state_d = FREE;
          qtr_d   = 2'd0;
        end
      end
      FREE: begin
        if (qend && qtr_q == 2'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Line drive follows the next state so the registered pins line up with the phase counters.
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      START: sda_d = (qtr_d == 2'd0);
      STOP:  sda_d = (qtr_d == 2'd1);
      ADDR, WDATA: begin
        scl_d = qtr_d[1];
        sda_d = tx_d[7];
      end
      ACK_A, ACK_W, RDATA: scl_d = qtr_d[1];
      MACK: begin
        scl_d = qtr_d[1];
        sda_d = last_byte;
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK_200M or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      rw_q      <= 1'b0;
      wrem_q    <= 3'd0;
      rdb_q     <= 3'd1;
      bcnt_q    <= 3'd1;
      gcnt_q    <= 4'd1;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      rd_data_q <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      wrem_q    <= wrem_d;
      rdb_q     <= rdb_d;
      bcnt_q    <= bcnt_d;
      gcnt_q    <= gcnt_d;
      nack_q    <= nack_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      rd_data_q <= rd_data_d;
      rd_en_q   <= rd_en_d;
    end
  end

  // Payload and shift registers carry no reset; they are reloaded on every accepted request.
  always_ff @(posedge CLK_200M) begin
    adr_q  <= adr_d;
    tx_q   <= tx_d;
    wbuf_q <= wbuf_d;
    rx_q   <= rx_d;
  end

  assign scl_o      = scl_q;
  assign sda_o      = sda_q;
  assign rd_data    = rd_data_q;
  assign rd_data_en = rd_en_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_master_interface.sv
// Bench for i2c_master_interface: directed transactions, a bus-level slave/monitor,
// and queue-based scoreboards for bus bytes, read strobes and busy lengths.
`timescale 1ns/1ps
module tb_i2c_master_interface;
  localparam int Q = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_flg = 1'b0;
  logic        rd_flg = 1'b0;
  logic [6:0]  adr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  wr_bytes = '0;
  logic [2:0]  rd_bytes = '0;
  logic [3:0]  rd_channels = '0;
  logic [31:0] rd_data;
  logic        rd_data_en;
  logic        scl_o, sda_o, sda_i, busy;

  logic slave_sda = 1'b1;
  logic slave_present = 1'b1;
  assign sda_i = sda_o & slave_sda;

  always #2.5 clk = ~clk;

  i2c_master_interface #(.QUARTER(Q)) dut (
    .CLK_200M(clk), .reset(reset_n), .wr_flg(wr_flg), .rd_flg(rd_flg), .adr(adr),
    .wr_data(wr_data), .wr_bytes(wr_bytes), .rd_bytes(rd_bytes), .rd_channels(rd_channels),
    .rd_data(rd_data), .rd_data_en(rd_data_en), .scl_o(scl_o), .sda_o(sda_o),
    .sda_i(sda_i), .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event, value 0x%0h, nothing expected", name, act);
  endtask

  logic [8:0]  exp_bus[$];
  logic [31:0] exp_rd[$];
  int          exp_busy[$];
  int          exp_stops = 0;
  int          stops = 0;
  logic [7:0]  slv_bytes[8];
  bit          skip_busy = 1'b0;

  // Bus monitor and slave model, sampled on the falling system clock edge.
  logic scl_prev = 1'b1, sda_prev = 1'b1, in_frame = 1'b0, have_rise = 1'b0;
  logic rw_s = 1'b0, viol = 1'b0, line_s;
  logic [7:0] cur = '0;
  int bitidx = 0, bytenum = 0, hi_cnt = 0, cyc = 0, last_rise = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      in_frame  = 1'b0;
      slave_sda = 1'b1;
      scl_prev  = 1'b1;
      sda_prev  = 1'b1;
    end else begin
      line_s = sda_i;
      if (scl_o && scl_prev && sda_prev && !line_s) begin
        if (in_frame && bitidx != 0) viol = 1'b1;
        in_frame = 1'b1; bitidx = 0; bytenum = 0; have_rise = 1'b0; cur = '0;
      end else if (scl_o && scl_prev && !sda_prev && line_s) begin
        if (in_frame) begin
          if (bitidx != 0) viol = 1'b1;
          stops++;
        end
        in_frame = 1'b0;
      end
      if (in_frame) begin
        if (scl_o && !scl_prev) begin
          if (have_rise) check("scl_period", cyc - last_rise, 4 * Q);
          have_rise = 1'b1; last_rise = cyc; hi_cnt = 1;
          if (bitidx < 8) begin
            cur = {cur[6:0], line_s};
            bitidx++;
          end else begin
            if (bytenum == 0) rw_s = cur[0];
            if (exp_bus.size() == 0) unexpected("bus_byte", {23'd0, cur, line_s});
            else check("bus_byte", {23'd0, cur, line_s}, {23'd0, exp_bus.pop_front()});
            bitidx = 0;
            bytenum++;
          end
        end else if (!scl_o && scl_prev) begin
          check("sda_stable_scl_high", {31'd0, viol}, 32'd0);
          viol = 1'b0;
          if (bitidx == 8 && (bytenum == 0 || !rw_s)) slave_sda = !slave_present;
          else if (bitidx < 8 && bytenum >= 1 && rw_s) slave_sda = slv_bytes[(bytenum - 1) % 8][7 - bitidx];
          else slave_sda = 1'b1;
        end else if (scl_o) begin
          hi_cnt++;
          if (hi_cnt == 2 * Q + Q / 2) slave_sda = 1'b1;
        end
      end
      scl_prev = scl_o;
      sda_prev = sda_i;
    end
  end

  always @(negedge clk) begin
    if (reset_n && rd_data_en) begin
      if (exp_rd.size() == 0) unexpected("rd_data", rd_data);
      else check("rd_data", rd_data, exp_rd.pop_front());
    end
  end

  int busy_len = 0;
  always @(negedge clk) begin
    if (busy) begin
      busy_len++;
    end else if (busy_len != 0) begin
      if (!skip_busy) begin
        if (exp_busy.size() == 0) unexpected("busy_len", busy_len);
        else check("busy_len", busy_len, exp_busy.pop_front());
      end
      busy_len = 0;
    end
  end

  task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [2:0] n,
                          input logic also_rd);
    @(posedge clk); #1;
    adr = a; wr_data = d; wr_bytes = n; wr_flg = 1'b1; rd_flg = also_rd;
    @(posedge clk); #1;
    wr_flg = 1'b0; rd_flg = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a, input logic [2:0] nb, input logic [3:0] ch);
    @(posedge clk); #1;
    adr = a; rd_bytes = nb; rd_channels = ch; rd_flg = 1'b1;
    @(posedge clk); #1;
    rd_flg = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check("busy_done_in_time", {31'd0, busy}, 32'd0);
    repeat (4 * Q) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) slv_bytes[i] = 8'hFF;
    repeat (5) @(negedge clk);
    check("reset_scl", {31'd0, scl_o}, 32'd1);
    check("reset_sda", {31'd0, sda_o}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_rd_en", {31'd0, rd_data_en}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Two-byte write, slave ACKs every byte.
    exp_bus.push_back({8'h6A, 1'b0}); exp_bus.push_back({8'hD2, 1'b0});
    exp_bus.push_back({8'hA3, 1'b0});
    exp_busy.push_back(114 * Q); exp_stops++;
    do_write(7'h35, 32'h0000D2A3, 3'd2, 1'b0);
    wait_idle(200 * Q);

    // Three groups of two bytes.
    slv_bytes[0] = 8'h0F; slv_bytes[1] = 8'hFF; slv_bytes[2] = 8'h01;
    slv_bytes[3] = 8'h23; slv_bytes[4] = 8'h08; slv_bytes[5] = 8'h00;
    exp_bus.push_back({8'h6B, 1'b0});
    exp_bus.push_back({8'h0F, 1'b0}); exp_bus.push_back({8'hFF, 1'b0});
    exp_bus.push_back({8'h01, 1'b0}); exp_bus.push_back({8'h23, 1'b0});
    exp_bus.push_back({8'h08, 1'b0}); exp_bus.push_back({8'h00, 1'b1});
    exp_rd.push_back(32'h00000FFF); exp_rd.push_back(32'h00000123);
    exp_rd.push_back(32'h00000800);
    exp_busy.push_back(258 * Q); exp_stops++;
    do_read(7'h35, 3'd2, 4'd3);
    wait_idle(300 * Q);

    // No slave: address NACK aborts straight to STOP.
    slave_present = 1'b0;
    exp_bus.push_back({8'h6A, 1'b1});
    exp_busy.push_back(42 * Q); exp_stops++;
    do_write(7'h35, 32'h0000D2A3, 3'd2, 1'b0);
    wait_idle(200 * Q);
    slave_present = 1'b1;

    // Simultaneous write and read requests, then a read request while busy.
    exp_bus.push_back({8'h24, 1'b0}); exp_bus.push_back({8'h5C, 1'b0});
    exp_busy.push_back(78 * Q); exp_stops++;
    do_write(7'h12, 32'h0000005C, 3'd1, 1'b1);
    repeat (100) @(negedge clk);
    do_read(7'h35, 3'd2, 4'd3);
    wait_idle(200 * Q);

    // Address-only probe.
    exp_bus.push_back({8'h6A, 1'b0});
    exp_busy.push_back(42 * Q); exp_stops++;
    do_write(7'h35, 32'hFFFFFFFF, 3'd0, 1'b0);
    wait_idle(200 * Q);

    // rd_bytes=0 and rd_channels=0 both behave as 1.
    slv_bytes[0] = 8'hA5;
    exp_bus.push_back({8'h6B, 1'b0}); exp_bus.push_back({8'hA5, 1'b1});
    exp_rd.push_back(32'h000000A5);
    exp_busy.push_back(78 * Q); exp_stops++;
    do_read(7'h35, 3'd0, 4'd0);
    wait_idle(200 * Q);

    // wr_bytes=7 behaves as 4.
    exp_bus.push_back({8'h6A, 1'b0}); exp_bus.push_back({8'h11, 1'b0});
    exp_bus.push_back({8'h22, 1'b0}); exp_bus.push_back({8'h33, 1'b0});
    exp_bus.push_back({8'h44, 1'b0});
    exp_busy.push_back(186 * Q); exp_stops++;
    do_write(7'h35, 32'h11223344, 3'd7, 1'b0);
    wait_idle(300 * Q);

    // Asynchronous reset in the middle of a write.
    skip_busy = 1'b1;
    do_write(7'h35, 32'h0000D2A3, 3'd2, 1'b0);
    repeat (10 * Q) @(negedge clk);
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    check("midreset_scl", {31'd0, scl_o}, 32'd1);
    check("midreset_sda", {31'd0, sda_o}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_rd_en", {31'd0, rd_data_en}, 32'd0);
    check("midreset_rd_data", rd_data, 32'd0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (50 * Q) @(negedge clk);
    check("post_reset_scl", {31'd0, scl_o}, 32'd1);
    check("post_reset_sda", {31'd0, sda_o}, 32'd1);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    skip_busy = 1'b0;

    check("bus_queue_drained", exp_bus.size(), 32'd0);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    check("busy_queue_drained", exp_busy.size(), 32'd0);
    check("stop_count", stops, exp_stops);
    check("sda_stable_final", {31'd0, viol}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
